byte_encode_stream: RTL and testbench

// Streaming ByteEncode_d packer. Upstream of bits2bytes in the encode path.
// - Accepts one d-bit coefficient per handshake (N_COEFFS per frame).
// - Concatenates coefficients LSB-first into a bit stream.
// - Emits that stream one byte per handshake: byte k = stream bits [8k+7:8k],
//   the same ordering bits2bytes applies to a packed vector.

---
 rtl/byte_encode_stream.sv | 115 +++++++++++
 tb/tb_byte_encode_stream.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_encode_stream.sv
// Streaming ByteEncode_d packer: d-bit coefficients in, LSB-first byte stream out; a byte is valid the cycle after the push that completes it.
// Byte backpressure holds byte_o stable and stalls coefficient intake through the fill>=8 gate, so nothing is dropped.
module byte_encode_stream #(
  parameter int N_COEFFS = 256,
  parameter int D_MAX    = 12,
  parameter int ACC_W    = D_MAX + 7
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [3:0]       d_i,
  input  logic             coeff_valid_i,
  input  logic [D_MAX-1:0] coeff_i,
  output logic             coeff_ready_o,
  output logic             byte_valid_o,
  output logic [7:0]       byte_o,
  output logic             byte_last_o,
  input  logic             byte_ready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  localparam int FW = $clog2(ACC_W + 1);
  localparam int CW = $clog2(N_COEFFS + 1);
  localparam int BW = $clog2(N_COEFFS * D_MAX / 8 + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_nx;
  logic [ACC_W-1:0] acc;
  logic [FW-1:0]    fill;
  logic [CW-1:0]    coeff_cnt;
  logic [BW-1:0]    byte_cnt;
  logic [3:0]       d_q;
  logic             err_q;

  logic             d_legal;
  logic             start_ok;
  logic             push;
  logic             pop;
  logic [BW-1:0]    last_idx;
  logic [D_MAX-1:0] coeff_m;
  logic [ACC_W-1:0] acc_base;
  logic [ACC_W-1:0] acc_ins;
  logic [FW-1:0]    ins_pos;
  logic [FW-1:0]    fill_nx;

  assign d_legal  = (d_i != 4'd0) && (d_i <= 4'(D_MAX));
  assign start_ok = (state == IDLE) && start_i && d_legal;
  assign last_idx = BW'(N_COEFFS / 8) * BW'(d_q) - BW'(1);

  assign coeff_ready_o = (state == RUN) && (fill < FW'(8)) && (coeff_cnt < CW'(N_COEFFS));
  assign byte_valid_o  = (state == RUN) && (fill >= FW'(8));
  assign byte_o        = acc[7:0];
  assign byte_last_o   = byte_valid_o && (byte_cnt == last_idx);
  assign busy_o        = (state == RUN);
  assign done_o        = (state == DONE);
  assign err_o         = err_q;

  assign push = coeff_valid_i && coeff_ready_o;
  assign pop  = byte_valid_o && byte_ready_i;

  // A pop shifts the accumulator first, so a simultaneous push lands at fill-8.
  assign coeff_m  = coeff_i & ~({D_MAX{1'b1}} << d_q);
  assign acc_base = pop ? (acc >> 8) : acc;
  assign ins_pos  = pop ? (fill - FW'(8)) : fill;
  assign acc_ins  = push ? (ACC_W'(coeff_m) << ins_pos) : '0;
  assign fill_nx  = fill + (push ? FW'(d_q) : FW'(0)) - (pop ? FW'(8) : FW'(0));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_ok) state_nx = RUN;
      RUN:     if (pop && byte_last_o) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc       <= '0;
      fill      <= '0;
      coeff_cnt <= '0;
      byte_cnt  <= '0;
      d_q       <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= (state == IDLE) && start_i && !d_legal;
      if (start_ok) begin
        d_q       <= d_i;
        acc       <= '0;
        fill      <= '0;
        coeff_cnt <= '0;
        byte_cnt  <= '0;
      end else if (state == RUN) begin
        acc  <= acc_base | acc_ins;
        fill <= fill_nx;
        if (push) coeff_cnt <= coeff_cnt + CW'(1);
        if (pop)  byte_cnt  <= byte_cnt + BW'(1);
      end
    end
  end

endmodule

// File: tb/tb_byte_encode_stream.sv
// Bench for byte_encode_stream: bit-queue reference model checked on every byte handshake, plus literal frame checks.
module tb_byte_encode_stream;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic [3:0]  d_i;
  logic        coeff_valid_i;
  logic [11:0] coeff_i;
  logic        coeff_ready_o;
  logic        byte_valid_o;
  logic [7:0]  byte_o;
  logic        byte_last_o;
  logic        byte_ready_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  always #5 clk_i = ~clk_i;

  byte_encode_stream dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .d_i(d_i),
    .coeff_valid_i(coeff_valid_i), .coeff_i(coeff_i), .coeff_ready_o(coeff_ready_o),
    .byte_valid_o(byte_valid_o), .byte_o(byte_o), .byte_last_o(byte_last_o),
    .byte_ready_i(byte_ready_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Driver-owned frame info
  logic [11:0] coeffs [256];
  int          drv_d = 0;
  int          start_cnt = 0;

  // Model-owned results
  int          nbytes = 0;
  int          last_pos = -1;
  logic [7:0]  first_b [4];

  // Reference: coefficients become a plain bit list, bytes are taken 8 bits at a time.
  initial begin : compare
    bit         bq[$];
    int         mdl_d = 0;
    int         seen_start = 0;
    logic       pend = 1'b0;
    logic       hold = 1'b0;
    logic [7:0] hold_b = 8'h00;
    logic [7:0] exp_b;
    forever begin
      @(negedge clk_i);
      if (rst_ni !== 1'b1) begin
        bq.delete();
        pend = 1'b0;
        hold = 1'b0;
        continue;
      end
      if (start_cnt != seen_start) begin
        seen_start = start_cnt;
        bq.delete();
        mdl_d = drv_d;
        nbytes = 0;
        last_pos = -1;
      end
      if (hold) begin
        check("hold_valid", {31'd0, byte_valid_o}, 32'd1);
        check("hold_byte", {24'd0, byte_o}, {24'd0, hold_b});
      end
      if (pend || done_o) check("done_pulse", {31'd0, done_o}, {31'd0, pend});
      pend = 1'b0;
      if (byte_valid_o && byte_ready_i) begin
        if (bq.size() < 8) begin
          check("model_underrun", bq.size(), 32'd8);
        end else begin
          for (int i = 0; i < 8; i++) exp_b[i] = bq.pop_front();
          check("byte", {24'd0, byte_o}, {24'd0, exp_b});
        end
        check("byte_last", {31'd0, byte_last_o}, {31'd0, (nbytes == mdl_d * 32 - 1)});
        if (nbytes < 4) first_b[nbytes] = byte_o;
        if (nbytes == mdl_d * 32 - 1) begin
          last_pos = nbytes;
          pend = 1'b1;
        end
        nbytes++;
      end
      if (coeff_valid_i && coeff_ready_o)
        for (int i = 0; i < mdl_d; i++) bq.push_back(coeff_i[i]);
      hold = byte_valid_o && !byte_ready_i;
      hold_b = byte_o;
    end
  end

  task automatic run_frame(input int d, input int npush, input int stall_at,
                           input int stall_len, input int ign_at);
    int   idx = 0;
    int   cyc = 0;
    logic acc;
    logic seen_last = 1'b0;
    @(posedge clk_i); #1;
    start_i = 1'b1;
    d_i = 4'(d);
    drv_d = d;
    start_cnt++;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    check("busy_after_start", {31'd0, busy_o}, 32'd1);
    coeff_valid_i = (npush > 0);
    coeff_i = coeffs[0];
    byte_ready_i = 1'b1;
    while (1) begin
      @(negedge clk_i);
      acc = coeff_valid_i && coeff_ready_o;
      if (byte_valid_o && byte_ready_i && byte_last_o) seen_last = 1'b1;
      if (stall_len > 0 && cyc == stall_at + stall_len - 1) begin
        check("stall_coeff_ready", {31'd0, coeff_ready_o}, 32'd0);
        check("stall_byte_valid", {31'd0, byte_valid_o}, 32'd1);
      end
      @(posedge clk_i); #1;
      cyc++;
      if (acc) idx++;
      coeff_valid_i = (idx < npush);
      coeff_i = (idx < 256) ? coeffs[idx] : 12'h000;
      byte_ready_i = !(stall_len > 0 && cyc >= stall_at && cyc < stall_at + stall_len);
      start_i = (cyc == ign_at);
      if (cyc == ign_at) d_i = 4'd0;
      if (cyc == ign_at + 1) begin
        check("start_busy_no_err", {31'd0, err_o}, 32'd0);
        check("start_busy_still_busy", {31'd0, busy_o}, 32'd1);
      end
      if (seen_last) break;
      if (npush < 256 && idx >= npush) break;
      if (cyc > 6000) begin
        check("frame_timeout", 32'd0, 32'd1);
        break;
      end
    end
    coeff_valid_i = 1'b0;
    byte_ready_i = 1'b1;
    start_i = 1'b0;
    if (seen_last) begin
      check("done_state", {31'd0, done_o}, 32'd1);
      @(posedge clk_i); #1;
      check("idle_done_low", {31'd0, done_o}, 32'd0);
      check("idle_busy_low", {31'd0, busy_o}, 32'd0);
    end
  endtask

  task automatic bad_start(input logic [3:0] d);
    @(posedge clk_i); #1;
    start_i = 1'b1;
    d_i = d;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    check("err_pulse", {31'd0, err_o}, 32'd1);
    check("err_busy", {31'd0, busy_o}, 32'd0);
    @(posedge clk_i); #1;
    check("err_one_cycle", {31'd0, err_o}, 32'd0);
    check("err_still_idle", {31'd0, busy_o}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"}, {24'd0, coeff_ready_o, byte_valid_o, byte_last_o, busy_o,
                           done_o, err_o, 2'b00}, 32'd0);
    check({tag, "_byte"}, {24'd0, byte_o}, 32'd0);
  endtask

  initial begin
    rst_ni = 1'b0;
    start_i = 1'b0;
    d_i = 4'd0;
    coeff_valid_i = 1'b0;
    coeff_i = 12'h000;
    byte_ready_i = 1'b1;
    #1;
    check_all_zero("reset");
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // d=12 full frame
    for (int i = 0; i < 256; i++) coeffs[i] = 12'(i * 29 + 7);
    coeffs[0] = 12'hABC;
    coeffs[1] = 12'h123;
    run_frame(12, 256, 0, 0, -1);
    check("d12_b0", {24'd0, first_b[0]}, 32'hBC);
    check("d12_b1", {24'd0, first_b[1]}, 32'h3A);
    check("d12_b2", {24'd0, first_b[2]}, 32'h12);
    check("d12_nbytes", nbytes, 384);
    check("d12_lastpos", last_pos, 383);

    // d=1 alternating 1,0 with junk in masked-off bits
    for (int i = 0; i < 256; i++) coeffs[i] = (i % 2 == 0) ? 12'hFF1 : 12'hAB0;
    run_frame(1, 256, 0, 0, -1);
    check("d1_b0", {24'd0, first_b[0]}, 32'h55);
    check("d1_b3", {24'd0, first_b[3]}, 32'h55);
    check("d1_nbytes", nbytes, 32);
    check("d1_lastpos", last_pos, 31);

    // d=4 masking
    for (int i = 0; i < 256; i++) coeffs[i] = 12'(i * 53 + 11);
    coeffs[0] = 12'h0F5;
    coeffs[1] = 12'h0F1;
    run_frame(4, 256, 0, 0, -1);
    check("d4_b0", {24'd0, first_b[0]}, 32'h15);
    check("d4_nbytes", nbytes, 128);

    // d=10 with a 20-cycle byte stall and an ignored start mid-frame
    for (int i = 0; i < 256; i++) coeffs[i] = 12'(i * 97 + 300);
    run_frame(10, 256, 100, 20, 200);
    check("d10_nbytes", nbytes, 320);
    check("d10_lastpos", last_pos, 319);

    // illegal frame sizes
    bad_start(4'd0);
    bad_start(4'd13);

    // reset mid-frame, then a clean frame
    for (int i = 0; i < 256; i++) coeffs[i] = 12'(i * 181 + 5);
    run_frame(11, 100, 0, 0, -1);
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    #1;
    check_all_zero("midreset");
    @(posedge clk_i); #1;
    check_all_zero("midreset_hold");
    rst_ni = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    check("post_reset_no_done", {31'd0, done_o}, 32'd0);
    run_frame(11, 256, 0, 0, -1);
    check("d11_nbytes", nbytes, 352);
    check("d11_lastpos", last_pos, 351);

    repeat (3) @(posedge clk_i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
